cdb_arbiter: RTL

//  Producer end of the CDB that the ROB, the RS and the map table consume.

---
 rtl/sys_defs.sv | 39 +++
 rtl/cdb_arbiter_fifo.sv | 73 +++++++
 rtl/cdb_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/sys_defs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sys_defs : shared CDB packet type and global macros for rob/rs/map table
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`ifndef SYS_DEFS_MACROS
`define SYS_DEFS_MACROS
`define ZERO_PREG 6'd0
`define CDB_WIDTH 2
`define TRUE      1'b1
`define FALSE     1'b0
`define SD        #1
`endif

package sys_defs;

  localparam int PREG_IDX_W = 6;

  typedef struct packed {
    logic                  valid;
    logic [PREG_IDX_W-1:0] tag;
    logic                  misprediction;
    logic                  taken_branch;
    logic [31:0]           branch_target;
  } CDB_PACKET;

  // The value an unused CDB slot must carry so listeners never see a stale tag
  function automatic CDB_PACKET cdb_idle();
    CDB_PACKET p;
    p.valid         = `FALSE;
    p.tag           = `ZERO_PREG;
    p.misprediction = `FALSE;
    p.taken_branch  = `FALSE;
    p.branch_target = 32'h0;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdb_fifo : per-FU completion buffer; squash empties it and drops the push
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module cdb_fifo
  import sys_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic                     push,
  input  CDB_PACKET                pkt_in,
  input  logic                     pop,
  output CDB_PACKET                head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  CDB_PACKET         mem_q [DEPTH];
  CDB_PACKET         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (squash) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = pkt_in;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdb_arbiter : buffers FU completions, broadcasts up to 2 per cycle round-robin
// Option      : CDB_BYPASS_EN lets an empty-FIFO FU skip its buffer when granted
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
module cdb_arbiter
  import sys_defs::*;
#(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          squash,
  input  logic [NUM_FU-1:0]             fu_valid,
  input  CDB_PACKET [NUM_FU-1:0]        fu_packet,
  output logic [NUM_FU-1:0]             fu_ready,
  output CDB_PACKET [`CDB_WIDTH-1:0]    cdb,
  output logic                          cdb_stall
);

  localparam int PTR_W = $clog2(NUM_FU);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_FU-1:0]            empty, full, accept, push, pop, byp, byp_ok;
  CDB_PACKET                    head  [NUM_FU];
  logic [CW-1:0]                count [NUM_FU];

  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  CDB_PACKET [`CDB_WIDTH-1:0]   cdb_q, cdb_d, sel_pkt;
  CDB_PACKET                    pkt;
  logic [PTR_W:0]               scan;
  logic [PTR_W-1:0]             src, last_idx;
  logic [1:0]                   slot_n;
  logic                         grant_any;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
    cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .squash (squash),
      .push   (push[g]),
      .pkt_in (fu_packet[g]),
      .pop    (pop[g]),
      .head   (head[g]),
      .empty  (empty[g]),
      .full   (full[g]),
      .count  (count[g])
    );
    assign fu_ready[g] = (count[g] < CW'(FIFO_DEPTH)) & ~squash;
  end

  assign accept = fu_valid & fu_ready;
  assign push   = accept & ~byp;

`ifdef CDB_BYPASS_EN
  assign byp_ok = empty & accept;
`else
  assign byp_ok = '0;
`endif

  always_comb begin
    pop       = '0;
    byp       = '0;
    slot_n    = '0;
    grant_any = 1'b0;
    last_idx  = rr_ptr_q;
    scan      = '0;
    src       = '0;
    pkt       = cdb_idle();
    sel_pkt   = {cdb_idle(), cdb_idle()};
    for (int k = 0; k < NUM_FU; k++) begin
      scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(NUM_FU)) scan = scan - (PTR_W+1)'(NUM_FU);
      src = scan[PTR_W-1:0];
      if (slot_n < 2'd2 && (!empty[src] || byp_ok[src])) begin
        // An empty source can only be eligible through the bypass path
        pkt                 = empty[src] ? fu_packet[src] : head[src];
        pkt.valid           = `TRUE;
        sel_pkt[slot_n[0]]  = pkt;
        pop[src]            = !empty[src];
        byp[src]            = empty[src];
        last_idx            = src;
        grant_any           = 1'b1;
        slot_n              = slot_n + 2'd1;
      end
    end
    cdb_d    = {cdb_idle(), cdb_idle()};
    rr_ptr_d = rr_ptr_q;
    if (!squash) begin
      cdb_d = sel_pkt;
      if (grant_any)
        rr_ptr_d = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      cdb_q    <= {cdb_idle(), cdb_idle()};
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  assign cdb       = cdb_q;
  assign cdb_stall = |full;

endmodule
`default_nettype wire
